// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single memory port between instruction fetch (I)
// and data load/store (D), with an optional watchdog that aborts unanswered transactions.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [1:0]  d_req_size,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_addr_valid,
    output logic [31:0] mem_addr,
    output logic        mem_data_valid,
    output logic [31:0] mem_data,
    output logic [1:0]  io_mode,
    input  logic        mem_ready,
    input  logic [31:0] mem_input,
    output logic [1:0]  grant_debug,
    output logic [1:0]  state_debug
);

    // state | meaning
    // IDLE  | sample requests, grant one and launch it on the memory bus
    // BUSY  | transaction on the bus, waiting for mem_ready or watchdog expiry
    // DONE  | one cycle with ack/err high; requests ignored
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [31:0] LP_WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic        LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);

    state_t      r_state;
    logic        r_last_d;
    logic        r_win_d;
    logic [31:0] r_wait_cnt;
    logic        r_i_ack;
    logic        r_i_err;
    logic [31:0] r_i_rdata;
    logic        r_d_ack;
    logic        r_d_err;
    logic [31:0] r_d_rdata;
    logic        r_mem_addr_valid;
    logic [31:0] r_mem_addr;
    logic        r_mem_data_valid;
    logic [31:0] r_mem_data;
    logic [1:0]  r_io_mode;
    logic [1:0]  r_grant;

    logic        w_any_req;
    logic        w_grant_d;
    logic [1:0]  w_d_mode;
    logic        w_timeout;

    assign w_any_req = i_req_valid | d_req_valid;
    // Under contention the port that did not win last time goes next.
    assign w_grant_d = d_req_valid & (~i_req_valid | ~r_last_d);
    assign w_d_mode  = (d_req_size == 2'b11) ? 2'b10 : d_req_size;
    assign w_timeout = LP_WDOG_EN & (r_wait_cnt == LP_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_last_d         <= 1'b0;
            r_win_d          <= 1'b0;
            r_wait_cnt       <= '0;
            r_i_ack          <= 1'b0;
            r_i_err          <= 1'b0;
            r_i_rdata        <= '0;
            r_d_ack          <= 1'b0;
            r_d_err          <= 1'b0;
            r_d_rdata        <= '0;
            r_mem_addr_valid <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_data_valid <= 1'b0;
            r_mem_data       <= '0;
            r_io_mode        <= 2'b00;
            r_grant          <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_win_d          <= w_grant_d;
                        r_last_d         <= w_grant_d;
                        r_wait_cnt       <= '0;
                        r_mem_addr_valid <= 1'b1;
                        r_mem_data_valid <= w_grant_d & d_req_we;
                        r_mem_addr       <= w_grant_d ? d_req_addr : i_req_addr;
                        r_io_mode        <= w_grant_d ? w_d_mode : 2'b10;
                        r_grant          <= w_grant_d ? 2'b10 : 2'b01;
                        if (w_grant_d && d_req_we) begin
                            r_mem_data <= d_req_wdata;
                        end
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        if (r_win_d) begin
                            r_d_rdata <= mem_input;
                            r_d_ack   <= 1'b1;
                        end else begin
                            r_i_rdata <= mem_input;
                            r_i_ack   <= 1'b1;
                        end
                        r_mem_addr_valid <= 1'b0;
                        r_mem_data_valid <= 1'b0;
                        r_state          <= ST_DONE;
                    end else if (w_timeout) begin
                        if (r_win_d) begin
                            r_d_err <= 1'b1;
                        end else begin
                            r_i_err <= 1'b1;
                        end
                        r_mem_addr_valid <= 1'b0;
                        r_mem_data_valid <= 1'b0;
                        r_state          <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    r_i_ack <= 1'b0;
                    r_i_err <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_d_err <= 1'b0;
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack          = r_i_ack;
    assign i_err          = r_i_err;
    assign i_rdata        = r_i_rdata;
    assign d_ack          = r_d_ack;
    assign d_err          = r_d_err;
    assign d_rdata        = r_d_rdata;
    assign mem_addr_valid = r_mem_addr_valid;
    assign mem_addr       = r_mem_addr;
    assign mem_data_valid = r_mem_data_valid;
    assign mem_data       = r_mem_data;
    assign io_mode        = r_io_mode;
    assign grant_debug    = r_grant;
    assign state_debug    = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the core's single memory port between two requesters: instruction fetch (I port) and data load/store (D port). Uses round-robin arbitration under contention and presents one transaction at a time on the existing mem_addr_valid/mem_ready bus. Returns read data and a one-cycle ack to the granted requester. A configurable watchdog aborts transactions whose memory never responds.

Parameters:
TIMEOUT_CYCLES, 64, BUSY cycles without mem_ready before abort with err; 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge only
reset  in  1  synchronous, active-high
i_req_valid  in  1  fetch request pending; held until i_ack/i_err
i_req_addr  in  32  fetch address; always a word read
i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_err  out  1  one-cycle pulse: fetch timed out
i_rdata  out  32  fetch data
d_req_valid  in  1  data request pending; held until d_ack/d_err
d_req_we  in  1  1=store, 0=load
d_req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
d_req_addr  in  32  data address
d_req_wdata  in  32  store data
d_ack  out  1  one-cycle pulse: data transaction complete
d_err  out  1  one-cycle pulse: data transaction timed out
d_rdata  out  32  load data (raw mem_input)
mem_addr_valid  out  1  memory transaction active
mem_addr  out  32  memory address
mem_data_valid  out  1  write strobe, high for the whole store transaction
mem_data  out  32  write data
io_mode  out  2  access size forwarded to memory
mem_ready  in  1  memory completion
mem_input  in  32  memory read data
grant_debug  out  2  01=I granted, 10=D granted, 00=none
state_debug  out  2  00 IDLE, 01 BUSY, 10 DONE

Behaviour:
- Reset values:
  - All valid/ack/err outputs 0.
  - mem_addr, mem_data, i_rdata, d_rdata = 0.
  - io_mode = 0, grant_debug = 0, state IDLE.
  - last_grant = I.
- Reset mid-operation: the transaction is dropped with no ack/err. Outputs take reset values on the next cycle.
- Request inputs are sampled only in IDLE. Requesters hold all fields stable while valid and not yet acked/erred.
- IDLE:
  - Neither valid: stay in IDLE.
  - One valid: grant that port.
  - Both valid: grant the port not equal to last_grant. The first contention after reset therefore goes to D.
  - On grant, at the same edge:
    - Register mem_addr.
    - Register mem_data (D store only; otherwise hold the previous value).
    - io_mode = 10 for I, d_req_size for D (11 mapped to 10).
    - mem_data_valid = D & d_req_we.
    - mem_addr_valid = 1.
    - last_grant = winner; wait counter = 0.
    - Go to BUSY.
- BUSY:
  - mem_addr_valid stays high and all mem_* outputs stay stable.
  - mem_ready=1: capture mem_input into the winner's rdata; rdata is also updated on stores. Pulse the winner's ack, drop mem_addr_valid/mem_data_valid, go to DONE.
  - mem_ready=0, watchdog enabled, counter == TIMEOUT_CYCLES-1: pulse the winner's err, leave rdata unchanged, drop the valids, go to DONE.
  - Otherwise increment the counter.
  - mem_ready and timeout on the same cycle: mem_ready wins (ack, not err).
- DONE: exactly one cycle; ack/err high during it. Requests are not evaluated. Next state IDLE.
- Latency with mem_ready already high: accept edge, then one BUSY cycle, then one DONE cycle. Minimum 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles.
- mem_ready is ignored in IDLE and DONE.
- rdata holds its value until the next ack on that port. ack and err are never high together.
- grant_debug reflects the winner during BUSY and DONE, and is 00 in IDLE.

Test Plan:
- Single fetch: i_req_valid, addr 0x100, mem_ready tied high, mem_input 0x00500093 -> mem_addr_valid is high exactly 1 cycle with mem_addr=0x100 and io_mode=10. i_ack pulses 1 cycle with i_rdata=0x00500093, 3 cycles after acceptance.
- Contention right after reset: both valid, I addr 0x0, D load addr 0x40 size 00 -> D granted first (io_mode=00, mem_data_valid=0). Then I granted. Then, with both re-requesting, D granted again (alternation holds).
- Store: D we=1, size 01, addr 0x80, wdata 0xDEADBEEF, mem_ready delayed 4 cycles -> mem_addr_valid and mem_data_valid stay high for 5 BUSY cycles with fields stable. d_ack pulses once; i_ack is never asserted.
- Timeout: TIMEOUT_CYCLES=8, I request, mem_ready stuck low -> i_err pulses after 8 BUSY cycles. i_rdata is unchanged and i_ack stays 0. mem_ready first rising on cycle 8 instead -> i_ack, not i_err.
- Reset mid-BUSY: reset asserted on the 2nd BUSY cycle of a D load -> next cycle state_debug=00, mem_addr_valid=0, no d_ack/d_err ever. After reset, a simultaneous I/D request grants D.
- Stale request: I acked while i_req_valid remains high through DONE -> no regrant during DONE. The new request is evaluated in IDLE.
